// File: rtl/fetch_queue_f.sv
// fetch_queue_f: circular instruction FIFO between fetch and decode.
// Entries hold {PC, instruction, predictor taken bit}. A redirect (iFlush)
// empties the queue at the next edge. Head outputs are driven from the entry
// at the read pointer. When the queue is empty they show a NOP bubble.
module fetch_queue_f #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic                     iValidF,
  input  logic [XLEN-1:0]          iPCF,
  input  logic [XLEN-1:0]          iInstructionF,
  input  logic                     iPredTakenF,
  output logic                     oReadyF,
  input  logic                     iStallD,
  input  logic                     iFlush,
  output logic                     oValidD,
  output logic [XLEN-1:0]          oPCD,
  output logic [XLEN-1:0]          oInstructionD,
  output logic                     oPredTakenD,
  output logic [$clog2(DEPTH):0]   oCount
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            pred_taken;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic [AW-1:0]   w_rd_ptr_nxt;
  logic [AW-1:0]   w_wr_ptr_nxt;
  logic [CW-1:0]   w_count_nxt;
  entry_t          w_head;
  entry_t          w_wr_entry;

  // Occupancy status decoded from the registered count only.
  always_comb begin
    w_full  = (r_count == CW'(DEPTH));
    w_empty = (r_count == '0);
  end

  // Handshakes. A full queue never accepts a push, even when a pop is
  // happening in the same cycle. A redirect cancels both push and pop.
  always_comb begin
    w_push = iValidF && !w_full  && !iFlush;
    w_pop  = !w_empty && !iStallD && !iFlush;
  end

  // Next pointer and count values. Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    w_rd_ptr_nxt = r_rd_ptr;
    w_wr_ptr_nxt = r_wr_ptr;
    w_count_nxt  = r_count;
    if (iFlush) begin
      w_rd_ptr_nxt = '0;
      w_wr_ptr_nxt = '0;
      w_count_nxt  = '0;
    end else begin
      if (w_push) begin
        w_wr_ptr_nxt = r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        w_rd_ptr_nxt = r_rd_ptr + AW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + CW'(1);
        2'b01:   w_count_nxt = r_count - CW'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // Pointer and occupancy registers. Reset takes priority over everything else.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= w_rd_ptr_nxt;
      r_wr_ptr <= w_wr_ptr_nxt;
      r_count  <= w_count_nxt;
    end
  end

  // Pack the incoming fetch payload into an entry.
  always_comb begin
    w_wr_entry.pc         = iPCF;
    w_wr_entry.instr      = iInstructionF;
    w_wr_entry.pred_taken = iPredTakenF;
  end

  // Entry storage. Contents are don't-care until written, so there is no reset.
  always_ff @(posedge iClk) begin
    if (!iRst && w_push) begin
      r_mem[r_wr_ptr] <= w_wr_entry;
    end
  end

  // Head presentation. When the queue is empty, decode sees a NOP bubble with PC 0.
  always_comb begin
    w_head        = r_mem[r_rd_ptr];
    oValidD       = !w_empty;
    oReadyF       = !w_full;
    oCount        = r_count;
    oPCD          = '0;
    oInstructionD = NOP;
    oPredTakenD   = 1'b0;
    if (!w_empty) begin
      oPCD          = w_head.pc;
      oInstructionD = w_head.instr;
      oPredTakenD   = w_head.pred_taken;
    end
  end

`ifndef SYNTHESIS
  // Occupancy sanity: the count never exceeds DEPTH and a pop never happens on an empty queue.
  always_ff @(posedge iClk) begin
    if (!iRst) begin
      assert (r_count <= CW'(DEPTH))
        else $error("fetch_queue_f: count %0d exceeds DEPTH", r_count);
      assert (!(w_pop && w_empty))
        else $error("fetch_queue_f: pop from empty queue");
    end
  end
`endif

endmodule
